// File: rtl/game_flow_ctl.sv
// game_flow_ctl: frame-synchronised game-flow controller for the penalty simulator.
// Sequences START -> SHOOTER (-> KEEPER) -> ... -> END screens, counts rounds and
// scores, and forces a miss when a shot is not resolved within TIMEOUT_FRAMES frames.
// Every screen change is first requested (pending + next_state) and only committed
// on a frame_start edge, so the display never switches mid-frame.
// The FSM state is exposed directly as screen_sel.
module game_flow_ctl #(
    parameter int ROUNDS         = 5,
    parameter int TIMEOUT_FRAMES = 600,
    parameter int SCORE_W        = 4,
    localparam int RW            = $clog2(ROUNDS + 1),
    localparam int TW            = $clog2(TIMEOUT_FRAMES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               left_clicked,
    input  logic               solo_enable,
    input  logic               frame_start,
    input  logic               result_valid,
    input  logic               result_goal,
    output logic [1:0]         screen_sel,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] opp_score,
    output logic [RW-1:0]      round_idx,
    output logic               solo_mode,
    output logic               game_won
);

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_SHOOTER = 2'd1,
        ST_KEEPER  = 2'd2,
        ST_END     = 2'd3
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [RW-1:0]      ROUNDS_L  = RW'(ROUNDS);
    localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT_FRAMES - 1);

    state_t        state;
    state_t        next_state;
    logic          pending;
    logic          click_q;
    logic [TW-1:0] tmo_cnt;

    logic          click_rise;
    logic          in_play;
    logic          tmo_hit;
    logic          resolve;
    logic          shot_goal;
    logic [RW-1:0] round_inc;
    logic          round_done;

    // Decode click edges, shot resolution (result beats timeout) and round completion.
    always_comb begin
        click_rise = left_clicked & ~click_q;
        in_play    = (state == ST_SHOOTER) || (state == ST_KEEPER);
        tmo_hit    = in_play && !pending && frame_start && (tmo_cnt == TMO_LAST);
        resolve    = in_play && !pending && (result_valid || tmo_hit);
        shot_goal  = result_valid ? result_goal : 1'b0;
        round_inc  = round_idx + 1'b1;
        round_done = (round_inc == ROUNDS_L);
    end

    // Single FSM: request changes while idle, commit them on the next frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_START;
            next_state   <= ST_START;
            pending      <= 1'b0;
            click_q      <= 1'b0;
            tmo_cnt      <= '0;
            player_score <= '0;
            opp_score    <= '0;
            round_idx    <= '0;
            solo_mode    <= 1'b0;
            game_won     <= 1'b0;
        end else begin
            click_q <= left_clicked;
            if (pending) begin
                // Inputs are ignored until the requested change has been committed.
                if (frame_start) begin
                    state    <= next_state;
                    pending  <= 1'b0;
                    tmo_cnt  <= '0;
                    game_won <= (next_state == ST_END) && (player_score > opp_score);
                    // Scores stay on screen in START and clear only when a new game begins.
                    if (state == ST_START && next_state == ST_SHOOTER) begin
                        player_score <= '0;
                        opp_score    <= '0;
                        round_idx    <= '0;
                    end
                end
            end else begin
                case (state)
                    ST_START: begin
                        if (click_rise) begin
                            solo_mode  <= solo_enable;
                            next_state <= ST_SHOOTER;
                            pending    <= 1'b1;
                        end
                    end
                    ST_SHOOTER: begin
                        if (resolve) begin
                            tmo_cnt <= '0;
                            pending <= 1'b1;
                            if (shot_goal && player_score != SCORE_MAX)
                                player_score <= player_score + 1'b1;
                            if (solo_mode) begin
                                round_idx  <= round_inc;
                                next_state <= round_done ? ST_END : ST_SHOOTER;
                            end else begin
                                next_state <= ST_KEEPER;
                            end
                        end else if (frame_start) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    ST_KEEPER: begin
                        if (resolve) begin
                            tmo_cnt    <= '0;
                            pending    <= 1'b1;
                            round_idx  <= round_inc;
                            next_state <= round_done ? ST_END : ST_SHOOTER;
                            if (shot_goal && opp_score != SCORE_MAX)
                                opp_score <= opp_score + 1'b1;
                        end else if (frame_start) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (click_rise) begin
                            next_state <= ST_START;
                            pending    <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign screen_sel = state;

endmodule

// File: tb/tb_game_flow_ctl.sv
// tb_game_flow_ctl: directed and randomised game sequences for game_flow_ctl,
// checked against a transaction-level model of the game rules.
module tb_game_flow_ctl;

  localparam int ROUNDS = 5;
  localparam int TMO    = 3;
  localparam int SW     = 4;
  localparam int RW     = $clog2(ROUNDS + 1);
  localparam int SMAX   = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          left_clicked;
  logic          solo_enable;
  logic          frame_start;
  logic          result_valid;
  logic          result_goal;
  logic [1:0]    screen_sel;
  logic [SW-1:0] player_score;
  logic [SW-1:0] opp_score;
  logic [RW-1:0] round_idx;
  logic          solo_mode;
  logic          game_won;

  // clock / reset block
  always #5 clk = ~clk;

  game_flow_ctl #(
    .ROUNDS(ROUNDS),
    .TIMEOUT_FRAMES(TMO),
    .SCORE_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .left_clicked(left_clicked),
    .solo_enable(solo_enable),
    .frame_start(frame_start),
    .result_valid(result_valid),
    .result_goal(result_goal),
    .screen_sel(screen_sel),
    .player_score(player_score),
    .opp_score(opp_score),
    .round_idx(round_idx),
    .solo_mode(solo_mode),
    .game_won(game_won)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // game-level model: screen number, scores, completed rounds, mode, requested screen
  int m_screen, m_ps, m_os, m_rd, m_solo, m_next;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_screen"}, 32'(screen_sel), 32'(m_screen));
    check({tag, "_pscore"}, 32'(player_score), 32'(m_ps));
    check({tag, "_oscore"}, 32'(opp_score), 32'(m_os));
    check({tag, "_round"}, 32'(round_idx), 32'(m_rd));
    check({tag, "_solo"}, 32'(solo_mode), 32'(m_solo));
    check({tag, "_won"}, 32'(game_won), 32'((m_screen == 3 && m_ps > m_os) ? 1 : 0));
  endtask

  task automatic model_reset();
    m_screen = 0; m_ps = 0; m_os = 0; m_rd = 0; m_solo = 0; m_next = 0;
  endtask

  // driver: stray clicks and results while a change is pending (must be ignored)
  task automatic noise(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      left_clicked = 1'($urandom_range(0, 1));
      result_valid = 1'($urandom_range(0, 1));
      result_goal  = 1'($urandom_range(0, 1));
      tick();
    end
    left_clicked = 1'b0;
    result_valid = 1'b0;
    result_goal  = 1'b0;
    tick();
  endtask

  // driver: wait with noise, then a frame_start that commits the pending change
  task automatic commit(input string tag, input int gap);
    noise(gap);
    check_all({tag, "_hold"});
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_screen == 0 && m_next == 1) begin
      m_ps = 0; m_os = 0; m_rd = 0;
    end
    m_screen = m_next;
    check_all({tag, "_commit"});
  endtask

  // driver: click in START or END, optionally with a frame_start in the same cycle
  task automatic click_request(input string tag, input bit with_frame, input int gap);
    left_clicked = 1'b1;
    frame_start  = with_frame;
    tick();
    left_clicked = 1'b0;
    frame_start  = 1'b0;
    if (m_screen == 0) begin
      m_solo = int'(solo_enable);
      m_next = 1;
    end else begin
      m_next = 0;
    end
    check_all({tag, "_req"});
    commit(tag, gap);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // driver: one shot. kind 0 = result, 1 = timeout, 2 = result on the timeout frame
  task automatic shot(input string tag, input int kind, input bit goal);
    bit g;
    g = 1'b0;
    if (kind == 0) begin
      repeat ($urandom_range(0, TMO - 1)) frame_pulse();
      result_valid = 1'b1;
      result_goal  = goal;
      tick();
      g = goal;
    end else if (kind == 1) begin
      repeat (TMO) frame_pulse();
    end else begin
      repeat (TMO - 1) frame_pulse();
      result_valid = 1'b1;
      result_goal  = goal;
      frame_start  = 1'b1;
      tick();
      g = goal;
    end
    result_valid = 1'b0;
    result_goal  = 1'b0;
    frame_start  = 1'b0;
    if (m_screen == 1) begin
      if (g) m_ps = (m_ps < SMAX) ? m_ps + 1 : SMAX;
      if (m_solo != 0) begin
        m_rd++;
        m_next = (m_rd == ROUNDS) ? 3 : 1;
      end else begin
        m_next = 2;
      end
    end else begin
      if (g) m_os = (m_os < SMAX) ? m_os + 1 : SMAX;
      m_rd++;
      m_next = (m_rd == ROUNDS) ? 3 : 1;
    end
    check_all({tag, "_res"});
    commit(tag, $urandom_range(0, 5));
  endtask

  task automatic random_game(input string tag);
    int n;
    solo_enable = 1'($urandom_range(0, 1));
    click_request({tag, "_start"}, 1'($urandom_range(0, 1)), $urandom_range(0, 8));
    n = 0;
    while (m_screen != 3 && n < 12) begin
      shot({tag, "_shot"}, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      n++;
    end
    check({tag, "_ended"}, 32'(screen_sel), 32'd3);
  endtask

  initial begin
    rst = 1'b1; left_clicked = 1'b0; solo_enable = 1'b0; frame_start = 1'b0;
    result_valid = 1'b0; result_goal = 1'b0;
    model_reset();
    repeat (3) tick();
    check_all("reset");
    rst = 1'b0;
    tick();

    // solo game with a fixed outcome sequence; click coincides with a frame_start
    solo_enable = 1'b1;
    click_request("g1_start", 1'b1, 50);
    shot("g1_s1", 0, 1'b1);
    shot("g1_s2", 0, 1'b1);
    shot("g1_s3", 0, 1'b0);
    shot("g1_s4", 0, 1'b1);
    shot("g1_s5", 0, 1'b0);
    check("g1_final_ps", 32'(player_score), 32'd3);
    check("g1_final_round", 32'(round_idx), 32'd5);
    check("g1_final_won", 32'(game_won), 32'd1);

    // back to START: scores held
    click_request("g1_back", 1'b0, 3);

    // two-player game exercising timeout and result-vs-timeout race
    solo_enable = 1'b0;
    click_request("g2_start", 1'b0, 4);
    shot("g2_tmo_sh", 1, 1'b0);
    shot("g2_kp_goal", 0, 1'b1);
    shot("g2_race_sh", 2, 1'b1);
    shot("g2_tmo_kp", 1, 1'b0);
    while (m_screen != 3) shot("g2_rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    click_request("g2_back", 1'b0, 2);

    for (int gi = 0; gi < 4; gi++) begin
      random_game("rg");
      click_request("rg_back", 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    // reset in KEEPER with score 2:1
    solo_enable = 1'b0;
    click_request("r_start", 1'b0, 2);
    shot("r_s1", 0, 1'b1);
    shot("r_k1", 0, 1'b1);
    shot("r_s2", 0, 1'b1);
    check("r_pre_screen", 32'(screen_sel), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_all("r_after");

    // full game, END -> START keeps scores, next game start clears them
    random_game("h");
    click_request("h_back", 1'b0, 3);
    solo_enable = 1'b1;
    click_request("h_restart", 1'b0, 3);
    check("h_cleared_ps", 32'(player_score), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctl.md
# game_flow_ctl

Parametrised game-flow controller for the penalty simulator. It replaces the fixed start/solo state selector with a frame-synchronised state machine that sequences start, shooter, keeper and end screens. It counts rounds and scores, supports solo and two-player modes, and applies a per-shot timeout. It sits between the mouse controller and shot logic on the input side and the screen multiplexer and score overlay on the output side, all in the single VGA pixel clock domain.

## Interface
Parameters:
- ROUNDS, 5, shots per side before the game ends (1..15)
- TIMEOUT_FRAMES, 600, frames allowed per shot before it is forced to a miss (≥1)
- SCORE_W, 4, score counter width; ROUNDS < 2**SCORE_W

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- left_clicked  in  1  mouse left-button level
- solo_enable  in  1  mode switch level; sampled only when leaving START
- frame_start  in  1  one-cycle pulse at the start of each frame (vblank)
- result_valid  in  1  one-cycle pulse: the current shot is resolved
- result_goal  in  1  qualifies result_valid: 1 = goal, 0 = saved/missed
- screen_sel  out  2  0 START, 1 SHOOTER, 2 KEEPER, 3 END
- player_score  out  SCORE_W  goals scored by the player
- opp_score  out  SCORE_W  goals conceded by the player (two-player mode only)
- round_idx  out  $clog2(ROUNDS+1)  completed rounds
- solo_mode  out  1  mode latched for the current game
- game_won  out  1  in END: player_score > opp_score; 0 in every other state

## Operation
- Click detect: `left_clicked` is registered once. A rising edge is the registered value 0 together with the current value 1. Clicks are honoured only in START and END.
- Pending mechanism: every state change is first latched into a `pending` flag with a `next_state` register. The state register updates only on a cycle with frame_start=1 and pending=1, and pending clears on that same edge. While pending=1, further clicks, results and timeouts are ignored.
- START:
  - On a click, latch solo_mode ← solo_enable.
  - Request SHOOTER.
- SHOOTER (resolution = result_valid, or timeout treated as goal=0):
  - On a goal, player_score increments, saturating at 2**SCORE_W−1.
  - Two-player mode: request KEEPER.
  - Solo mode: round_idx increments. Request END if the new round_idx == ROUNDS, otherwise request SHOOTER again.
- KEEPER (two-player only):
  - On a goal, opp_score increments, saturating.
  - round_idx increments.
  - Request END if round_idx == ROUNDS, otherwise request SHOOTER.
- END:
  - Scores and round_idx hold.
  - On a click, request START.
- Counter clearing: player_score, opp_score and round_idx clear on the edge that commits START→SHOOTER, not on entering START. Scores therefore stay visible on the START screen after a game.
- Timeout: a frame counter of width $clog2(TIMEOUT_FRAMES+1) counts frame_start pulses in SHOOTER/KEEPER while pending=0. It clears on every state commit and on resolution. When count == TIMEOUT_FRAMES−1 and frame_start=1, the shot resolves as goal=0.
- Simultaneous result_valid and timeout in the same cycle: result_valid wins, and result_goal is used.
- result_valid in START or END is ignored.

## Timing
- Reset values: screen_sel=0, all scores 0, round_idx 0, solo_mode 0, game_won 0, pending 0, timeout counter 0, click register 0.
- Score/round latency: updated on the clock edge of the result_valid cycle, so visible the next cycle, independent of frame_start.
- State latency: a click rising at cycle t sets pending at edge t. screen_sel changes at the edge of the first cycle ≥ t+1 with frame_start=1. If frame_start=1 in cycle t itself, it does not commit the change.
- Reset asserted mid-game: the next edge forces the reset values. Any pending request is discarded.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- frame_start held high for several cycles: each cycle counts as a separate pulse. The driver must guarantee single-cycle pulses.

## Test plan
- Reset, click in START, frame_start 50 cycles later, with solo_enable=1: screen_sel 0→1 exactly at the frame_start edge, solo_mode=1, scores 0.
- Solo, ROUNDS=5: results goal,goal,miss,goal,miss, each followed by frame_start → player_score=3, round_idx=5, screen_sel=3, game_won=1, opp_score=0.
- Two-player, ROUNDS=2: SHOOTER goal, KEEPER goal, SHOOTER miss, KEEPER goal → screens 1,2,1,2,3. Final player 1, opp 2, game_won=0.
- Timeout with TIMEOUT_FRAMES=3: no result for 3 frame_starts in SHOOTER → round resolved as a miss, player_score unchanged. result_valid on the same cycle as the 3rd frame_start with goal=1 → player_score+1.
- Second result_valid and extra clicks while pending=1 → no score change, and the state still commits once.
- Reset asserted in KEEPER with score 2:1 → next cycle all outputs 0 and screen_sel=0. A click in END then returns to START with scores held until the next START→SHOOTER commit.
